frame_wr_mc_ctrl: RTL



---
 rtl/frame_wr_pkg.sv | 31 +++
 rtl/frame_wr_mc_ctrl_rr_arbiter.sv | 27 ++
 rtl/frame_wr_mc_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_wr_pkg.sv
// Shared types and helpers for the multi-channel frame write scheduler.
package frame_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam int unsigned ADDR_CALC_W = 64;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) result++;
        return result;
    endfunction

    // Start address of a transaction; callers truncate to the bus width.
    function automatic logic [ADDR_CALC_W-1:0] calc_addr(
        input logic [ADDR_CALC_W-1:0] base,
        input logic [ADDR_CALC_W-1:0] ch,
        input logic [ADDR_CALC_W-1:0] bidx,
        input logic [ADDR_CALC_W-1:0] offset,
        input logic [ADDR_CALC_W-1:0] frame_size,
        input logic [ADDR_CALC_W-1:0] buf_num
    );
        return base + ch * buf_num * frame_size + bidx * frame_size + offset;
    endfunction

endpackage

// File: rtl/frame_wr_mc_ctrl_rr_arbiter.sv
// Round-robin pick: first requester after the last grant, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned GW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_last,
    output logic          o_valid_c,
    output logic [GW-1:0] o_grant_c
);

    logic [GW-1:0] w_cand;

    always_comb begin
        o_valid_c = 1'b0;
        o_grant_c = '0;
        w_cand    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_cand = GW'((32'(i_last) + i) % N);
            if (!o_valid_c && i_req[w_cand]) begin
                o_valid_c = 1'b1;
                o_grant_c = w_cand;
            end
        end
    end

endmodule

// File: rtl/frame_wr_mc_ctrl.sv
// Multi-channel frame write scheduler: arbitrates per-channel FIFOs onto one
// mbus write port, each channel writing into its own ring of frame buffers.
module frame_wr_mc_ctrl
    import frame_wr_pkg::*;
#(
    parameter int unsigned MEM_DQ_WIDTH    = 16,
    parameter int unsigned BURST_LENGTH    = 8,
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned CH_NUM          = 2,
    parameter int unsigned LVL_WIDTH       = 10,
    parameter int unsigned BURST_NUM       = 15,
    parameter int unsigned ADDR_STEP       = 128,
    parameter int unsigned FRAME_SIZE      = 32'h0020_0000,
    parameter int unsigned FRAME_BUF_NUM   = 3,
    parameter int unsigned START_ADDRESS   = 0,
    localparam int unsigned W  = MEM_DQ_WIDTH * BURST_LENGTH,
    localparam int unsigned BW = clog2(FRAME_BUF_NUM)
) (
    input  logic                          i_axi_aclk,
    input  logic                          i_rst,
    input  logic [CH_NUM-1:0]             i_frame_start,
    input  logic [CH_NUM*LVL_WIDTH-1:0]   i_fifo_level,
    input  logic [CH_NUM*W-1:0]           i_fifo_rdata,
    output logic [CH_NUM-1:0]             o_fifo_rd_en,
    output logic [CH_NUM-1:0]             o_fifo_rd_rst,
    input  logic                          i_mbus_wdata_rq,
    input  logic                          i_mbus_wbusy,
    input  logic                          i_mbus_wsel,
    output logic                          o_mbus_wrq,
    output logic [CTRL_ADDR_WIDTH-1:0]    o_mbus_waddr,
    output logic [W-1:0]                  o_mbus_wdata,
    output logic                          o_mbus_wready,
    output logic [CH_NUM-1:0]             o_frame_done,
    output logic [CH_NUM*BW-1:0]          o_done_buf,
    output logic [CH_NUM-1:0]             o_overflow
);

    localparam int unsigned GW  = (CH_NUM > 1) ? clog2(CH_NUM) : 1;
    localparam int unsigned CAW = CTRL_ADDR_WIDTH;
    localparam int unsigned OW  = CAW + 1;

    state_e          r_state, w_state_nxt;
    logic [GW-1:0]   r_grant, w_grant_nxt;
    logic            r_wrq, w_wrq_nxt;
    logic            r_wready, w_wready_nxt;
    logic [CAW-1:0]  r_waddr, w_waddr_nxt;
    logic            r_busy_d;
    logic            w_busy_fall;
    logic            w_arb_valid;
    logic [GW-1:0]   w_arb_grant;
    logic [CH_NUM-1:0] w_elig;
    logic [CAW-1:0]  w_offset [CH_NUM];
    logic [BW-1:0]   w_wr_buf [CH_NUM];
    logic [W-1:0]    w_rdata  [CH_NUM];

    assign w_busy_fall = (r_state == ST_DATA) && r_busy_d && !i_mbus_wbusy;

    rr_arbiter #(
        .N  (CH_NUM),
        .GW (GW)
    ) u_arb (
        .i_req     (w_elig),
        .i_last    (r_grant),
        .o_valid_c (w_arb_valid),
        .o_grant_c (w_arb_grant)
    );

    genvar c;
    generate
        for (c = 0; c < CH_NUM; c++) begin : gen_ch
            logic            r_active, r_pending, r_overflow, r_done, r_rd_rst;
            logic [BW-1:0]   r_wr_buf, r_done_buf;
            logic [CAW-1:0]  r_offset;
            logic [OW-1:0]   w_next_off;
            logic [CAW-1:0]  w_off_upd;
            logic            w_lvl_ok, w_fits, w_granted, w_end, w_apply;

            assign w_next_off = {1'b0, r_offset} + OW'(ADDR_STEP);
            assign w_fits     = w_next_off <= OW'(FRAME_SIZE);
            assign w_lvl_ok   = i_fifo_level[c*LVL_WIDTH +: LVL_WIDTH] >= LVL_WIDTH'(BURST_NUM);
            assign w_granted  = (r_state != ST_IDLE) && (r_grant == GW'(c));
            assign w_end      = w_busy_fall && (r_grant == GW'(c));
            // A start on the busy channel waits for its transaction to finish.
            assign w_apply    = (i_frame_start[c] && !w_granted) ||
                                (w_end && (r_pending || i_frame_start[c]));
            assign w_off_upd  = w_end ? w_next_off[CAW-1:0] : r_offset;

            // A channel starting a frame this cycle sits out one arbitration round.
            assign w_elig[c]   = r_active && w_lvl_ok && w_fits && !i_frame_start[c];
            assign w_offset[c] = r_offset;
            assign w_wr_buf[c] = r_wr_buf;
            assign w_rdata[c]  = i_fifo_rdata[c*W +: W];

            assign o_frame_done[c]        = r_done;
            assign o_fifo_rd_rst[c]       = r_rd_rst;
            assign o_overflow[c]          = r_overflow;
            assign o_done_buf[c*BW +: BW] = r_done_buf;

            always_ff @(posedge i_axi_aclk or posedge i_rst) begin
                if (i_rst) begin
                    r_active   <= 1'b0;
                    r_pending  <= 1'b0;
                    r_overflow <= 1'b0;
                    r_done     <= 1'b0;
                    r_rd_rst   <= 1'b0;
                    r_wr_buf   <= '0;
                    r_done_buf <= '0;
                    r_offset   <= '0;
                end else begin
                    r_done   <= 1'b0;
                    r_rd_rst <= 1'b0;
                    if (w_end)
                        r_offset <= w_next_off[CAW-1:0];
                    if (i_frame_start[c] && w_granted && !w_end)
                        r_pending <= 1'b1;
                    if (r_active && w_lvl_ok && !w_fits)
                        r_overflow <= 1'b1;
                    if (w_apply) begin
                        r_pending  <= 1'b0;
                        r_active   <= 1'b1;
                        r_offset   <= '0;
                        r_overflow <= 1'b0;
                        r_rd_rst   <= 1'b1;
                        // Empty frames do not retire a buffer.
                        if (w_off_upd != '0) begin
                            r_done     <= 1'b1;
                            r_done_buf <= r_wr_buf;
                            r_wr_buf   <= (r_wr_buf == BW'(FRAME_BUF_NUM - 1)) ? '0 : r_wr_buf + BW'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge i_axi_aclk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_wrq    <= 1'b0;
            r_wready <= 1'b0;
            r_waddr  <= '0;
            r_busy_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_wrq    <= w_wrq_nxt;
            r_wready <= w_wready_nxt;
            r_waddr  <= w_waddr_nxt;
            r_busy_d <= i_mbus_wbusy;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_wrq_nxt    = r_wrq;
        w_wready_nxt = r_wready;
        w_waddr_nxt  = r_waddr;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt  = ST_REQ;
                    w_grant_nxt  = w_arb_grant;
                    w_wrq_nxt    = 1'b1;
                    w_wready_nxt = 1'b1;
                    w_waddr_nxt  = CAW'(calc_addr(ADDR_CALC_W'(START_ADDRESS),
                                                  ADDR_CALC_W'(w_arb_grant),
                                                  ADDR_CALC_W'(w_wr_buf[w_arb_grant]),
                                                  ADDR_CALC_W'(w_offset[w_arb_grant]),
                                                  ADDR_CALC_W'(FRAME_SIZE),
                                                  ADDR_CALC_W'(FRAME_BUF_NUM)));
                end
            end
            ST_REQ: begin
                if (i_mbus_wsel) begin
                    w_state_nxt = ST_DATA;
                    w_wrq_nxt   = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_busy_fall) begin
                    w_state_nxt  = ST_IDLE;
                    w_wready_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Data path follows the controller's word requests with no added latency.
    always_comb begin
        o_fifo_rd_en = '0;
        o_mbus_wdata = '0;
        if (r_state == ST_DATA) begin
            o_fifo_rd_en[r_grant] = i_mbus_wdata_rq;
            o_mbus_wdata          = w_rdata[r_grant];
        end
    end

    assign o_mbus_wrq    = r_wrq;
    assign o_mbus_wready = r_wready;
    assign o_mbus_waddr  = r_waddr;

endmodule
